// File: rtl/cnn_output_ctrl_pkg.sv
// Shared types and constants for the CNN output memory controller.
// Holds the sequencer state encoding and the drain FIFO sizing rule.
package cnn_output_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

    localparam int DEF_CHANNEL_WIDTH = 7;
    localparam int DEF_ROW_WIDTH     = 2;
    localparam int DEF_COL_WIDTH     = 2;
    localparam int DEF_BRAM_DEPTH    = 1152;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_READ_LATENCY  = 2;

    // Room for every read in flight plus two words of slack for backpressure.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/cnn_output_drain_fifo.sv
// Show-ahead FIFO buffering BRAM read data toward the drain stream.
// The head word is visible whenever the count is non-zero.
module cnn_output_drain_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_push_data,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_head,
    output logic [COUNT_WIDTH-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Accept only what fits and release only what is held.
    always_comb begin
        do_push = i_push && (o_count != COUNT_WIDTH'(DEPTH));
        do_pop  = i_pop && (o_count != '0);
        o_head  = mem[rptr];
    end

    // Storage array, no reset needed since the count qualifies it.
    always_ff @(posedge i_clock) begin
        if (do_push) mem[wptr] <= i_push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wptr    <= '0;
            rptr    <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            if (do_push && !do_pop)
                o_count <= o_count + COUNT_WIDTH'(1);
            else if (do_pop && !do_push)
                o_count <= o_count - COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cnn_output_mem_ctrl.sv
// Output feature BRAM sequencer: writes PE results in col/row/channel
// order, then drains an address range onto a credit-gated stream.
module cnn_output_mem_ctrl
    import cnn_output_ctrl_pkg::*;
#(
    parameter int OUTPUT_CHANNEL_WIDTH      = DEF_CHANNEL_WIDTH,
    parameter int OUTPUT_ROW_WIDTH          = DEF_ROW_WIDTH,
    parameter int OUTPUT_COL_WIDTH          = DEF_COL_WIDTH,
    parameter int OUTPUT_BRAM_DEPTH         = DEF_BRAM_DEPTH,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
    parameter int DATA_WIDTH                = DEF_DATA_WIDTH,
    parameter int BRAM_READ_LATENCY         = DEF_READ_LATENCY
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_start_channel,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_end_channel,
    input  logic [OUTPUT_ROW_WIDTH-1:0]          i_row_last,
    input  logic [OUTPUT_COL_WIDTH-1:0]          i_col_last,
    input  logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] i_drain_last,
    input  logic                                 i_res_valid,
    output logic                                 o_res_ready,
    input  logic [DATA_WIDTH-1:0]                i_res_data,
    output logic                                 o_mem_enable,
    output logic                                 o_mem_wenable,
    output logic [DATA_WIDTH-1:0]                o_mem_wdata,
    output logic [OUTPUT_CHANNEL_WIDTH-1:0]      o_wr_channel,
    output logic [OUTPUT_ROW_WIDTH-1:0]          o_wr_row,
    output logic [OUTPUT_COL_WIDTH-1:0]          o_wr_col,
    output logic                                 o_mem_renable,
    output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_rd_address,
    input  logic [DATA_WIDTH-1:0]                i_mem_rdata,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
    output logic [DATA_WIDTH-1:0]                o_out_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_cfg_error
);

    localparam int FIFO_DEPTH = fifo_depth(BRAM_READ_LATENCY);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int LAT        = BRAM_READ_LATENCY;
    localparam int CHW        = OUTPUT_CHANNEL_WIDTH;
    localparam int RW         = OUTPUT_ROW_WIDTH;
    localparam int CLW        = OUTPUT_COL_WIDTH;
    localparam int AW         = OUTPUT_BRAM_ADDRESS_WIDTH;

    ctrl_state_t   state_q;
    ctrl_state_t   state_d;

    logic [CHW-1:0] end_ch_q;
    logic [RW-1:0]  row_last_q;
    logic [CLW-1:0] col_last_q;
    logic [AW-1:0]  drain_last_q;
    logic [CHW-1:0] ch_q;
    logic [RW-1:0]  row_q;
    logic [CLW-1:0] col_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LAT-1:0] pipe_q;

    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CW-1:0]         outstanding;
    logic [CW:0]           credit_used;
    logic                  credit_ok;
    logic                  cmd_ok;
    logic                  cmd_go;
    logic                  res_fire;
    logic                  last_beat;
    logic                  last_addr;
    logic                  issue;
    logic                  pop;
    logic                  flush_empty;

    // Handshake, credit and completion terms shared by FSM and datapath.
    always_comb begin
        cmd_ok    = i_end_channel >= i_start_channel;
        cmd_go    = (state_q == IDLE) && i_start && cmd_ok;
        res_fire  = (state_q == WRITE) && i_res_valid;
        last_beat = (ch_q == end_ch_q) && (row_q == row_last_q)
                  && (col_q == col_last_q);
        last_addr = rd_ptr_q == drain_last_q;
        outstanding = '0;
        for (int i = 0; i < LAT; i++)
            outstanding = outstanding + CW'(pipe_q[i]);
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        credit_ok   = credit_used < (CW + 1)'(FIFO_DEPTH);
        issue       = (state_q == DRAIN) && credit_ok;
        pop         = (fifo_count != '0) && i_out_ready;
        flush_empty = (pipe_q == '0)
                    && ((fifo_count == '0)
                        || ((fifo_count == CW'(1)) && pop));
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cmd_go) state_d = WRITE;
            WRITE: if (res_fire && last_beat) state_d = DRAIN;
            DRAIN: if (issue && last_addr) state_d = FLUSH;
            FLUSH: if (flush_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded stream and read-port outputs.
    always_comb begin
        o_res_ready   = state_q == WRITE;
        o_busy        = state_q != IDLE;
        o_mem_renable = issue;
        o_rd_address  = issue ? rd_ptr_q : '0;
        o_out_valid   = fifo_count != '0;
        o_out_data    = o_out_valid ? fifo_head : '0;
    end

    // Command latch and col/row/channel write counters.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            end_ch_q     <= '0;
            row_last_q   <= '0;
            col_last_q   <= '0;
            drain_last_q <= '0;
            ch_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else if (cmd_go) begin
            end_ch_q     <= i_end_channel;
            row_last_q   <= i_row_last;
            col_last_q   <= i_col_last;
            drain_last_q <= i_drain_last;
            ch_q         <= i_start_channel;
            row_q        <= '0;
            col_q        <= '0;
        end else if (res_fire) begin
            if (col_q == col_last_q) begin
                col_q <= '0;
                if (row_q == row_last_q) begin
                    row_q <= '0;
                    ch_q  <= ch_q + CHW'(1);
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end else begin
                col_q <= col_q + CLW'(1);
            end
        end
    end

    // Registered write port: beat and its coordinates one cycle later.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_mem_enable  <= 1'b0;
            o_mem_wenable <= 1'b0;
            o_mem_wdata   <= '0;
            o_wr_channel  <= '0;
            o_wr_row      <= '0;
            o_wr_col      <= '0;
        end else begin
            o_mem_enable  <= res_fire;
            o_mem_wenable <= res_fire;
            if (res_fire) begin
                o_mem_wdata  <= i_res_data;
                o_wr_channel <= ch_q;
                o_wr_row     <= row_q;
                o_wr_col     <= col_q;
            end
        end
    end

    // Read pointer, latency tag pipe and status pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd_ptr_q    <= '0;
            pipe_q      <= '0;
            o_done      <= 1'b0;
            o_cfg_error <= 1'b0;
        end else begin
            if (cmd_go)
                rd_ptr_q <= '0;
            else if (issue && !last_addr)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            pipe_q[0] <= issue;
            for (int i = 1; i < LAT; i++)
                pipe_q[i] <= pipe_q[i-1];
            o_done      <= (state_q == FLUSH) && flush_empty;
            o_cfg_error <= (state_q == IDLE) && i_start && !cmd_ok;
        end
    end

    cnn_output_drain_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (FIFO_DEPTH),
        .COUNT_WIDTH (CW)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (pipe_q[LAT-1]),
        .i_push_data (i_mem_rdata),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_count     (fifo_count)
    );

endmodule

// File: tb/tb_cnn_output_mem_ctrl.sv
// Directed bench for cnn_output_mem_ctrl with a latency-2 BRAM model.
// Word at BRAM address a reads back as 16'hC000 + a.
module tb_cnn_output_mem_ctrl;

    localparam int CHW = 7;
    localparam int RW  = 2;
    localparam int CLW = 2;
    localparam int AW  = 11;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           i_reset, i_start, i_res_valid, i_out_ready;
    logic [CHW-1:0] i_start_channel, i_end_channel;
    logic [RW-1:0]  i_row_last;
    logic [CLW-1:0] i_col_last;
    logic [AW-1:0]  i_drain_last;
    logic [DW-1:0]  i_res_data, i_mem_rdata;
    logic           o_res_ready, o_mem_enable, o_mem_wenable;
    logic [DW-1:0]  o_mem_wdata, o_out_data;
    logic [CHW-1:0] o_wr_channel;
    logic [RW-1:0]  o_wr_row;
    logic [CLW-1:0] o_wr_col;
    logic           o_mem_renable, o_out_valid, o_busy, o_done, o_cfg_error;
    logic [AW-1:0]  o_rd_address;

    cnn_output_mem_ctrl #(
        .OUTPUT_CHANNEL_WIDTH (CHW),
        .OUTPUT_ROW_WIDTH     (RW),
        .OUTPUT_COL_WIDTH     (CLW),
        .OUTPUT_BRAM_DEPTH    (1152),
        .DATA_WIDTH           (DW),
        .BRAM_READ_LATENCY    (LAT)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_start_channel (i_start_channel),
        .i_end_channel   (i_end_channel),
        .i_row_last      (i_row_last),
        .i_col_last      (i_col_last),
        .i_drain_last    (i_drain_last),
        .i_res_valid     (i_res_valid),
        .o_res_ready     (o_res_ready),
        .i_res_data      (i_res_data),
        .o_mem_enable    (o_mem_enable),
        .o_mem_wenable   (o_mem_wenable),
        .o_mem_wdata     (o_mem_wdata),
        .o_wr_channel    (o_wr_channel),
        .o_wr_row        (o_wr_row),
        .o_wr_col        (o_wr_col),
        .o_mem_renable   (o_mem_renable),
        .o_rd_address    (o_rd_address),
        .i_mem_rdata     (i_mem_rdata),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_data      (o_out_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_cfg_error     (o_cfg_error)
    );

    // BRAM read port model: data appears LAT cycles after renable.
    logic [DW-1:0] rq [LAT];
    always @(posedge clk) begin
        rq[0] <= o_mem_renable ? (16'hC000 + {5'b0, o_rd_address}) : '0;
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign i_mem_rdata = rq[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] popq  [$];
    logic [AW-1:0] addrq [$];
    int n_done, n_cfg, n_wen, n_ren, stall_bad;
    int last_pop_cyc, done_cyc;
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;

    // Monitor away from the clock edge, after the stimulus settles.
    always @(negedge clk) begin
        #2;
        if (stalled && o_out_data !== held) stall_bad++;
        stalled = o_out_valid && !i_out_ready;
        held    = o_out_data;
        if (o_out_valid && i_out_ready) begin
            popq.push_back(o_out_data);
            last_pop_cyc = cyc;
        end
        if (o_mem_renable) begin
            addrq.push_back(o_rd_address);
            n_ren++;
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (o_cfg_error)   n_cfg++;
        if (o_mem_wenable) n_wen++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        popq.delete();
        addrq.delete();
        n_done = 0; n_cfg = 0; n_wen = 0; n_ren = 0; stall_bad = 0;
        last_pop_cyc = -100; done_cyc = -200;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && n_done == 0; i++)
            @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input int sc, input int ec, input int rl,
                       input int cl, input int dl);
        @(negedge clk);
        clear();
        i_start = 1'b1;
        i_start_channel = CHW'(sc);
        i_end_channel   = CHW'(ec);
        i_row_last      = RW'(rl);
        i_col_last      = CLW'(cl);
        i_drain_last    = AW'(dl);
    endtask

    // Hand-computed {channel,row,col} for ch 3..4, row_last 1, col_last 1.
    logic [10:0] coord_a [8] = '{11'h030, 11'h031, 11'h034, 11'h035,
                                 11'h040, 11'h041, 11'h044, 11'h045};

    initial begin : stim
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_res_valid = 1'b0;
        i_out_ready = 1'b0; i_res_data = '0;
        i_start_channel = '0; i_end_channel = '0;
        i_row_last = '0; i_col_last = '0; i_drain_last = '0;
        clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",   o_busy, 0);
        check("rst_ready",  o_res_ready, 0);
        check("rst_valid",  o_out_valid, 0);
        check("rst_ren",    o_mem_renable, 0);
        check("rst_wen",    o_mem_wenable, 0);
        check("rst_done",   o_done, 0);
        i_reset = 1'b0;

        // Tile A: 8 writes then drain 0..9 with ready held high.
        cmd(3, 4, 1, 1, 9);
        i_out_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b1; i_res_data = 16'd0;
        #1;
        check("a_ready",  o_res_ready, 1);
        check("a_busy",   o_busy, 1);
        check("a_wen_lat", o_mem_wenable, 0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            i_res_data = DW'(k);
            #1;
            check("a_wen",   o_mem_wenable, 1);
            check("a_men",   o_mem_enable, 1);
            check("a_wdata", o_mem_wdata, k - 1);
            check("a_coord", {o_wr_channel, o_wr_row, o_wr_col}, coord_a[k-1]);
        end
        @(negedge clk);
        i_res_valid = 1'b0;
        #1;
        check("a_wen_last",   o_mem_wenable, 1);
        check("a_wdata_last", o_mem_wdata, 7);
        check("a_coord_last", {o_wr_channel, o_wr_row, o_wr_col}, coord_a[7]);
        check("a_ready_drop", o_res_ready, 0);
        @(negedge clk);
        #1;
        check("a_wen_off", o_mem_wenable, 0);
        wait_done(200);
        #1;
        check("a_ndone", n_done, 1);
        check("a_nwen",  n_wen, 8);
        check("a_npop",  popq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check("a_pop",  popq[i], 16'hC000 + i);
            check("a_addr", addrq[i], i);
        end
        check("a_done_lag", done_cyc - last_pop_cyc, 1);
        check("a_idle",     o_busy, 0);
        check("a_pulse",    o_done, 0);

        // Rejected command: end below start.
        cmd(5, 2, 0, 0, 0);
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("e_cfg",   o_cfg_error, 1);
        check("e_busy",  o_busy, 0);
        @(negedge clk);
        #1;
        check("e_cfg_off", o_cfg_error, 0);
        check("e_busy2",   o_busy, 0);
        repeat (3) @(negedge clk);
        check("e_ncfg", n_cfg, 1);
        check("e_nwen", n_wen, 0);
        check("e_nren", n_ren, 0);

        // Tile B: single write, drain 0..11 under backpressure.
        cmd(0, 0, 0, 0, 11);
        i_out_ready = 1'b0;
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b1; i_res_data = 16'h0077;
        @(negedge clk);
        i_res_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("b_credit", n_ren, 4);
        check("b_npop0",  popq.size(), 0);
        check("b_valid",  o_out_valid, 1);
        check("b_head",   o_out_data, 16'hC000);
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            @(negedge clk);
            i_out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        i_out_ready = 1'b1;
        #1;
        check("b_ndone", n_done, 1);
        check("b_npop",  popq.size(), 12);
        check("b_nren",  n_ren, 12);
        for (int i = 0; i < 12; i++) begin
            check("b_pop",  popq[i], 16'hC000 + i);
            check("b_addr", addrq[i], i);
        end
        check("b_stable", stall_bad, 0);

        // Tile C: reset in the middle of the drain.
        cmd(1, 1, 0, 0, 30);
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b1; i_res_data = 16'h0055;
        @(negedge clk);
        i_res_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("c_busy", o_busy, 1);
        check("c_wdata_pre", o_mem_wdata, 16'h0055);
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        check("c_busy0",  o_busy, 0);
        check("c_ready0", o_res_ready, 0);
        check("c_ren0",   o_mem_renable, 0);
        check("c_addr0",  o_rd_address, 0);
        check("c_valid0", o_out_valid, 0);
        check("c_data0",  o_out_data, 0);
        check("c_men0",   o_mem_enable, 0);
        check("c_wen0",   o_mem_wenable, 0);
        check("c_wdata0", o_mem_wdata, 0);
        check("c_coord0", {o_wr_channel, o_wr_row, o_wr_col}, 0);
        check("c_done0",  o_done, 0);
        check("c_cfg0",   o_cfg_error, 0);
        i_reset = 1'b0;

        // Tile D: fresh tile after reset, 4 writes, drain 0..3.
        cmd(0, 1, 0, 1, 3);
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b1; i_res_data = 16'h0011;
        repeat (3) @(negedge clk);
        @(negedge clk);
        i_res_valid = 1'b0;
        wait_done(200);
        check("d_ndone", n_done, 1);
        check("d_nwen",  n_wen, 4);
        check("d_npop",  popq.size(), 4);
        for (int i = 0; i < 4; i++)
            check("d_pop", popq[i], 16'hC000 + i);

        // Tile E: start pulsed during WRITE, single-word drain.
        cmd(2, 2, 1, 0, 0);
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b1; i_res_data = 16'h0022;
        @(negedge clk);
        i_start = 1'b1; i_start_channel = 7'd0; i_end_channel = 7'd9;
        i_drain_last = 11'd5;
        @(negedge clk);
        i_start = 1'b0; i_res_valid = 1'b0;
        wait_done(200);
        repeat (5) @(negedge clk);
        #1;
        check("f_ndone", n_done, 1);
        check("f_nwen",  n_wen, 2);
        check("f_nren",  n_ren, 1);
        check("f_addr",  addrq[0], 0);
        check("f_npop",  popq.size(), 1);
        check("f_pop",   popq[0], 16'hC000);
        check("f_ncfg",  n_cfg, 0);
        check("f_idle",  o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_output_mem_ctrl.md
Name: cnn_output_mem_ctrl

Overview:
Sequencer for the CNN output feature BRAM. It accepts one tile command, then writes a stream of PE-array results into the output memory in col→row→channel order by driving the write data-point coordinates. It then drains a programmed address range out of the BRAM onto a valid/ready stream, absorbing the BRAM read latency and downstream backpressure. It sits between the PE accumulator stage, the output memory wrapper and the DMA/writeback engine.

Parameters:
OUTPUT_CHANNEL_WIDTH, 7, channel index width
OUTPUT_ROW_WIDTH, 2, row index width
OUTPUT_COL_WIDTH, 2, col index width
OUTPUT_BRAM_DEPTH, 1152, BRAM words
OUTPUT_BRAM_ADDRESS_WIDTH, $clog2(OUTPUT_BRAM_DEPTH), read address width
DATA_WIDTH, 16, data word width
BRAM_READ_LATENCY, 2, cycles from renable/address to valid i_mem_rdata (1..4)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  command strobe, sampled only in IDLE
i_start_channel  in  OUTPUT_CHANNEL_WIDTH  first channel (inclusive)
i_end_channel  in  OUTPUT_CHANNEL_WIDTH  last channel (inclusive)
i_row_last  in  OUTPUT_ROW_WIDTH  last row index
i_col_last  in  OUTPUT_COL_WIDTH  last col index
i_drain_last  in  OUTPUT_BRAM_ADDRESS_WIDTH  last drain address (drain reads 0..i_drain_last)
i_res_valid  in  1  result beat valid
o_res_ready  out  1  result beat accepted
i_res_data  in  DATA_WIDTH  result word
o_mem_enable  out  1  port-A enable
o_mem_wenable  out  1  port-A write enable
o_mem_wdata  out  DATA_WIDTH  write data
o_wr_channel / o_wr_row / o_wr_col  out  channel/row/col widths  write data-point coordinates
o_mem_renable  out  1  port-B read enable
o_rd_address  out  OUTPUT_BRAM_ADDRESS_WIDTH  read address
i_mem_rdata  in  DATA_WIDTH  BRAM read data
o_out_valid  out  1  drain beat valid
i_out_ready  in  1  drain beat accepted
o_out_data  out  DATA_WIDTH  drain word
o_busy  out  1  not IDLE
o_done  out  1  one-cycle pulse at tile completion
o_cfg_error  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (any state, mid-op included): state IDLE; all outputs 0; counters, latency pipe and FIFO cleared; in-flight read data discarded.
- States: IDLE → WRITE → DRAIN → FLUSH → IDLE.
- IDLE: on i_start with i_end_channel >= i_start_channel, latch the config, set channel=start, row=0, col=0 and go to WRITE. With end < start, pulse o_cfg_error next cycle and stay IDLE. i_start is ignored outside IDLE.
- WRITE: o_res_ready=1. On a handshake, the next cycle drives o_mem_enable=o_mem_wenable=1, o_mem_wdata=beat and coordinates = the counter values at the handshake (registered, latency 1).
- Counter order: col increments first; col wraps at col_last → row++; row wraps at row_last → channel++.
- When the beat with channel=end, row=row_last, col=col_last is accepted, the state goes to DRAIN. o_res_ready drops the cycle after that handshake.
- Beat count = (end-start+1)*(row_last+1)*(col_last+1). Max 128*4*4 = 2048; count register 12 bits.
- DRAIN: issue o_mem_renable=1 with o_rd_address=rd_ptr only when outstanding + fifo_count < FIFO_DEPTH (FIFO_DEPTH = BRAM_READ_LATENCY+2). rd_ptr increments on each issue.
- After issuing i_drain_last, go to FLUSH. i_drain_last=0 means exactly 1 read.
- Latency pipe: shift register of BRAM_READ_LATENCY valid bits. Its tail pushes i_mem_rdata into the FIFO.
- FIFO head drives o_out_valid/o_out_data; pop on o_out_valid && i_out_ready. o_out_data stays stable while o_out_valid && !i_out_ready.
- Simultaneous push and pop are allowed; count unchanged. Credit gating means the FIFO never overflows.
- FLUSH: when the latency pipe and FIFO are both empty, pulse o_done for 1 cycle and return to IDLE. o_busy=0 from that cycle.
- Address arithmetic is unsigned; rd_ptr never exceeds i_drain_last, so no wrap.

Decomposition:
- Package cnn_output_ctrl_pkg: state enum (IDLE, WRITE, DRAIN, FLUSH), default width constants, localparam function for FIFO_DEPTH.
- One sub-module: cnn_output_drain_fifo. Synchronous show-ahead FIFO, parameters DATA_WIDTH/DEPTH, exposes count.

Test Plan:
- Start ch 3..4, row_last=1, col_last=1, i_res_valid held high, data=k → 8 writes, coordinates (3,0,0),(3,0,1),(3,1,0)…(4,1,1), each o_mem_wenable 1 cycle after its handshake.
- Start with end=2, start=5 → o_cfg_error pulses once, o_busy stays 0, no memory activity.
- Drain i_drain_last=9, i_out_ready=1, BRAM model latency 2 → 10 outputs from addresses 0..9 in order, o_done 1 cycle after the last pop.
- Drain with i_out_ready toggled randomly / held low 20 cycles → no lost or duplicated word, o_out_data stable while stalled, renable stops once credits are exhausted.
- Assert i_reset in the middle of DRAIN → next cycle all outputs 0, state IDLE. A fresh start then completes normally.
- i_start pulsed during WRITE and i_drain_last=0 → extra start ignored, single read at address 0, done once.
